// File: rtl/bus_codes_pkg.sv
// Shared bus code encoding for the datapath bus. Both the bus source mux and
// the destination loader import these constants so the two ends agree.
package bus_codes_pkg;

    localparam int DEFAULT_WIDTH = 8;
    // Codes 0..19 carry meaning; anything at or above this is a no-op.
    localparam int NUM_CODES     = 20;

    localparam logic [4:0] SEL_NONE = 5'd0;
    localparam logic [4:0] SEL_AC   = 5'd1;
    localparam logic [4:0] SEL_C3   = 5'd2;
    localparam logic [4:0] SEL_C2   = 5'd3;
    localparam logic [4:0] SEL_C1   = 5'd4;
    localparam logic [4:0] SEL_RN2  = 5'd5;
    localparam logic [4:0] SEL_RK2  = 5'd6;
    localparam logic [4:0] SEL_RM2  = 5'd7;
    localparam logic [4:0] SEL_RN1  = 5'd8;
    localparam logic [4:0] SEL_RK1  = 5'd9;
    localparam logic [4:0] SEL_RM1  = 5'd10;
    localparam logic [4:0] SEL_RT   = 5'd11;
    localparam logic [4:0] SEL_RP   = 5'd12;
    localparam logic [4:0] SEL_DR   = 5'd13;
    localparam logic [4:0] SEL_AR   = 5'd14;
    localparam logic [4:0] SEL_MEM  = 5'd15;
    localparam logic [4:0] SEL_RR   = 5'd16;
    localparam logic [4:0] SEL_RT4  = 5'd17;
    localparam logic [4:0] SEL_RL1  = 5'd18;
    localparam logic [4:0] SEL_RL2  = 5'd19;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // True for codes that name a datapath register (MEM is not a register).
    function automatic logic is_reg_code(input logic [4:0] code);
        return (code >= SEL_AC) && (code <= SEL_RL2) && (code != SEL_MEM);
    endfunction

    // True for the counter/pointer registers that support increment.
    function automatic logic is_inc_code(input logic [4:0] code);
        return (code == SEL_AR) || (code == SEL_RP) || (code == SEL_C1) ||
               (code == SEL_C2) || (code == SEL_C3) || (code == SEL_AC);
    endfunction

endpackage

// File: rtl/bus_mem_wr_fsm.sv
// One-outstanding memory write engine. Captures address/data when a MEM load
// is accepted and holds the request until the memory acknowledges.
//
// Handshake: the request is "valid" while state == MEM_WAIT; addr/data are
// held stable for the whole request. mem_wr_ack is the "ready": the transfer
// completes on the first rising edge where ack is sampled 1 with the request
// up. Ack with no request outstanding is ignored. A new MEM load is accepted
// only from IDLE, so writes are separated by at least one idle cycle.
module bus_mem_wr_fsm
    import bus_codes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_mem,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [WIDTH-1:0] ar,
    input  logic             mem_wr_ack,
    output mem_state_e       state,
    output logic [WIDTH-1:0] mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic             ld_err
);

    mem_state_e       state_next;
    logic [WIDTH-1:0] addr_next;
    logic [WIDTH-1:0] data_next;
    logic             ld_err_next;

    // State register plus the address/data latches and the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            ld_err      <= 1'b0;
        end else begin
            state       <= state_next;
            mem_wr_addr <= addr_next;
            mem_wr_data <= data_next;
            ld_err      <= ld_err_next;
        end
    end

    // Next state: accept MEM loads in IDLE, reject them while a write is pending.
    always_comb begin
        state_next  = state;
        addr_next   = mem_wr_addr;
        data_next   = mem_wr_data;
        ld_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (ld_mem) begin
                    addr_next  = ar;
                    data_next  = bus_in;
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (ld_mem) begin
                    ld_err_next = 1'b1;
                end
                if (mem_wr_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/bus_dest_loader.sv
// Destination side of the shared datapath bus: decodes the destination code,
// loads the selected register, increments counter/pointer registers and hands
// MEM-code writes to the memory write engine.
module bus_dest_loader
    import bus_codes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [4:0]       dest_sel,
    input  logic             ld,
    input  logic             inc,
    input  logic [4:0]       inc_sel,
    input  logic             mem_wr_ack,
    output logic [WIDTH-1:0] ac,
    output logic [WIDTH-1:0] c3,
    output logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] c1,
    output logic [WIDTH-1:0] rn2,
    output logic [WIDTH-1:0] rk2,
    output logic [WIDTH-1:0] rm2,
    output logic [WIDTH-1:0] rn1,
    output logic [WIDTH-1:0] rk1,
    output logic [WIDTH-1:0] rm1,
    output logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] rp,
    output logic [WIDTH-1:0] dr,
    output logic [WIDTH-1:0] ar,
    output logic [WIDTH-1:0] rr,
    output logic [WIDTH-1:0] rt4,
    output logic [WIDTH-1:0] rl1,
    output logic [WIDTH-1:0] rl2,
    output logic             mem_wr_req,
    output logic [WIDTH-1:0] mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic             busy,
    output logic             ld_err,
    output logic [2:0]       cnt_zero
);

    // Register bank indexed by bus code; slot SEL_MEM is never loaded.
    logic [WIDTH-1:0]     regs [1:NUM_CODES-1];
    logic [NUM_CODES-1:1] load_en;
    logic [NUM_CODES-1:1] inc_en;
    logic                 ld_mem;
    mem_state_e           mem_state;

    // Per-register load/increment enables; a load to the same target wins.
    always_comb begin
        load_en = '0;
        inc_en  = '0;
        for (int i = 1; i < NUM_CODES; i++) begin
            load_en[i] = ld && (dest_sel == 5'(i)) && is_reg_code(5'(i));
            inc_en[i]  = inc && (inc_sel == 5'(i)) && is_inc_code(5'(i)) && !load_en[i];
        end
    end

    // Register bank update: load from bus or increment modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_CODES; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_CODES; i++) begin
                if (load_en[i]) begin
                    regs[i] <= bus_in;
                end else if (inc_en[i]) begin
                    regs[i] <= regs[i] + WIDTH'(1);
                end
            end
        end
    end

    assign ld_mem = ld && (dest_sel == SEL_MEM);

    bus_mem_wr_fsm #(
        .WIDTH (WIDTH)
    ) u_mem_wr_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_mem      (ld_mem),
        .bus_in      (bus_in),
        .ar          (regs[SEL_AR]),
        .mem_wr_ack  (mem_wr_ack),
        .state       (mem_state),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .ld_err      (ld_err)
    );

    // Request and busy both mean "a write is outstanding".
    assign mem_wr_req = (mem_state == MEM_WAIT);
    assign busy       = (mem_state == MEM_WAIT);

    assign ac  = regs[SEL_AC];
    assign c3  = regs[SEL_C3];
    assign c2  = regs[SEL_C2];
    assign c1  = regs[SEL_C1];
    assign rn2 = regs[SEL_RN2];
    assign rk2 = regs[SEL_RK2];
    assign rm2 = regs[SEL_RM2];
    assign rn1 = regs[SEL_RN1];
    assign rk1 = regs[SEL_RK1];
    assign rm1 = regs[SEL_RM1];
    assign rt  = regs[SEL_RT];
    assign rp  = regs[SEL_RP];
    assign dr  = regs[SEL_DR];
    assign ar  = regs[SEL_AR];
    assign rr  = regs[SEL_RR];
    assign rt4 = regs[SEL_RT4];
    assign rl1 = regs[SEL_RL1];
    assign rl2 = regs[SEL_RL2];

    assign cnt_zero = {(c3 == '0), (c2 == '0), (c1 == '0)};

endmodule

// File: tb/tb_bus_dest_loader.sv
module tb_bus_dest_loader;

  localparam int W = 8;
  localparam logic [4:0] C_AC  = 5'd1;
  localparam logic [4:0] C_C3  = 5'd2;
  localparam logic [4:0] C_C2  = 5'd3;
  localparam logic [4:0] C_C1  = 5'd4;
  localparam logic [4:0] C_RT  = 5'd11;
  localparam logic [4:0] C_RP  = 5'd12;
  localparam logic [4:0] C_DR  = 5'd13;
  localparam logic [4:0] C_AR  = 5'd14;
  localparam logic [4:0] C_MEM = 5'd15;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] bus_in;
  logic [4:0]   dest_sel;
  logic         ld;
  logic         inc;
  logic [4:0]   inc_sel;
  logic         mem_wr_ack;
  logic [W-1:0] ac, c3, c2, c1, rn2, rk2, rm2, rn1, rk1, rm1;
  logic [W-1:0] rt, rp, dr, ar, rr, rt4, rl1, rl2;
  logic         mem_wr_req;
  logic [W-1:0] mem_wr_addr;
  logic [W-1:0] mem_wr_data;
  logic         busy;
  logic         ld_err;
  logic [2:0]   cnt_zero;

  bus_dest_loader #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .dest_sel(dest_sel),
    .ld(ld), .inc(inc), .inc_sel(inc_sel), .mem_wr_ack(mem_wr_ack),
    .ac(ac), .c3(c3), .c2(c2), .c1(c1), .rn2(rn2), .rk2(rk2), .rm2(rm2),
    .rn1(rn1), .rk1(rk1), .rm1(rm1), .rt(rt), .rp(rp), .dr(dr), .ar(ar),
    .rr(rr), .rt4(rt4), .rl1(rl1), .rl2(rl2),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .ld_err(ld_err),
    .cnt_zero(cnt_zero)
  );

  // DUT registers gathered by code for compact comparison
  logic [W-1:0] act [0:31];
  always_comb begin
    for (int i = 0; i < 32; i++) act[i] = '0;
    act[1]  = ac;  act[2]  = c3;  act[3]  = c2;  act[4]  = c1;
    act[5]  = rn2; act[6]  = rk2; act[7]  = rm2; act[8]  = rn1;
    act[9]  = rk1; act[10] = rm1; act[11] = rt;  act[12] = rp;
    act[13] = dr;  act[14] = ar;  act[16] = rr;  act[17] = rt4;
    act[18] = rl1; act[19] = rl2;
  end

  // scoreboard / model state
  logic [W-1:0]   m [0:31];
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] cur_mem;
  logic           exp_busy;
  logic           exp_err;
  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic is_reg(input logic [4:0] c);
    return (c >= 5'd1) && (c <= 5'd19) && (c != C_MEM);
  endfunction

  function automatic logic is_incable(input logic [4:0] c);
    return (c == C_AR) || (c == C_RP) || (c == C_C1) ||
           (c == C_C2) || (c == C_C3) || (c == C_AC);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    exp_q.delete();
    cur_mem  = '0;
    exp_busy = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic check_regs();
    for (int i = 1; i < 20; i++) begin
      if (i != 15) check($sformatf("reg_%0d", i), 32'(act[i]), 32'(m[i]));
    end
    check("cnt_zero", 32'(cnt_zero), 32'({m[C_C3] == '0, m[C_C2] == '0, m[C_C1] == '0}));
  endtask

  task automatic check_mem();
    check("mem_wr_req", 32'(mem_wr_req), 32'(exp_busy));
    check("busy", 32'(busy), 32'(exp_busy));
    check("ld_err", 32'(ld_err), 32'(exp_err));
    if (exp_busy) begin
      check("mem_wr_addr", 32'(mem_wr_addr), 32'(cur_mem[2*W-1:W]));
      check("mem_wr_data", 32'(mem_wr_data), 32'(cur_mem[W-1:0]));
    end
  endtask

  // driver: one clock of stimulus, model update, then checks after the edge
  task automatic cycle(input logic l, input logic [4:0] ds, input logic [W-1:0] b,
                       input logic i_, input logic [4:0] is, input logic ack);
    logic [W-1:0] ar_pre;
    logic         next_busy;
    logic         accepted;
    ar_pre    = m[C_AR];
    next_busy = exp_busy;
    accepted  = 1'b0;
    exp_err   = 1'b0;
    ld = l; dest_sel = ds; bus_in = b; inc = i_; inc_sel = is; mem_wr_ack = ack;
    if (exp_busy && ack) next_busy = 1'b0;
    if (l && ds == C_MEM) begin
      if (!exp_busy) begin
        exp_q.push_back({ar_pre, b});
        next_busy = 1'b1;
        accepted  = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (i_ && is_incable(is) && !(l && ds == is)) m[is] = m[is] + 8'd1;
    if (l && is_reg(ds)) m[ds] = b;
    @(posedge clk);
    #1;
    exp_busy = next_busy;
    ld = 1'b0; dest_sel = '0; bus_in = '0; inc = 1'b0; inc_sel = '0; mem_wr_ack = 1'b0;
    if (accepted) begin
      check("sb_not_empty", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) cur_mem = exp_q.pop_front();
    end
    check_regs();
    check_mem();
  endtask

  initial begin
    logic [4:0] rc;
    logic [4:0] ic;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ld = 1'b0; dest_sel = '0; bus_in = '0; inc = 1'b0; inc_sel = '0; mem_wr_ack = 1'b0;
    model_reset();
    #1;
    check_regs();
    check_mem();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // plain register load
    cycle(1'b1, C_DR, 8'hA5, 1'b0, 5'd0, 1'b0);

    // memory write with ack held low for three cycles
    cycle(1'b1, C_AR, 8'h10, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, C_MEM, 8'h3C, 1'b0, 5'd0, 1'b0);
    repeat (3) cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0);

    // rejected MEM load during wait, with AR increment alongside
    cycle(1'b1, C_MEM, 8'h77, 1'b1, C_AR, 1'b0);
    cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1);

    // second write; ack together with a new MEM load is rejected
    cycle(1'b1, C_MEM, 8'h55, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, C_MEM, 8'h99, 1'b0, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0);

    // counter wrap and same-cycle load/increment
    cycle(1'b1, C_C1, 8'hFF, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 8'h00, 1'b1, C_C1, 1'b0);
    cycle(1'b1, C_C1, 8'h07, 1'b1, C_C1, 1'b0);
    cycle(1'b1, C_C2, 8'h05, 1'b1, C_C3, 1'b0);
    cycle(1'b1, C_AC, 8'hFF, 1'b1, C_RP, 1'b0);
    cycle(1'b0, 5'd0, 8'h00, 1'b1, C_AC, 1'b0);

    // no-op codes, non-incrementable target, stray ack
    cycle(1'b1, 5'd31, 8'hEE, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 5'd0, 8'hEE, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 5'd20, 8'hEE, 1'b1, 5'd25, 1'b0);
    cycle(1'b0, 5'd0, 8'h00, 1'b1, C_RT, 1'b0);
    cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1);

    // random register traffic
    for (int k = 0; k < 24; k++) begin
      rc = 5'($urandom_range(1, 19));
      if (rc == C_MEM) rc = C_DR;
      ic = 5'($urandom_range(0, 20));
      cycle(1'($urandom_range(0, 1)), rc, 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ic, 1'b0);
    end

    // asynchronous reset in the middle of a pending write
    cycle(1'b1, C_MEM, 8'hC7, 1'b0, 5'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    check_mem();
    check("addr_after_rst", 32'(mem_wr_addr), 32'd0);
    check("data_after_rst", 32'(mem_wr_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1);
    cycle(1'b1, C_RP, 8'h42, 1'b0, 5'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_dest_loader.md
Name: bus_dest_loader

Overview:
Destination side of the shared datapath bus. It decodes a 5-bit destination code and loads the bus value into the selected datapath register. It also increments the counter/pointer registers and turns writes to the MEM code into a one-outstanding memory write handshake. The register outputs feed the bus source multiplexer.

Parameters:
WIDTH, 8, width of the bus and of every register.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bus_in  input  WIDTH  current bus value
dest_sel  input  5  destination code; same encoding as the bus source select
ld  input  1  load strobe, one register per cycle
inc  input  1  increment strobe
inc_sel  input  5  increment target code
mem_wr_ack  input  1  memory write accepted
ac, c3, c2, c1, rn2, rk2, rm2, rn1, rk1, rm1, rt, rp, dr, ar, rr, rt4, rl1, rl2  output  WIDTH each  registered datapath registers
mem_wr_req  output  1  memory write request
mem_wr_addr  output  WIDTH  latched write address
mem_wr_data  output  WIDTH  latched write data
busy  output  1  memory write outstanding
ld_err  output  1  one-cycle pulse: load rejected
cnt_zero  output  3  {c3==0, c2==0, c1==0}, combinational from registers

Behaviour:
- Code map for dest_sel and inc_sel: 00001 AC, 00010 C3, 00011 C2, 00100 C1, 00101 RN2, 00110 RK2, 00111 RM2, 01000 RN1, 01001 RK1, 01010 RM1, 01011 RT, 01100 RP, 01101 DR, 01110 AR, 01111 MEM, 10000 RR, 10001 RT4, 10010 RL1, 10011 RL2.
- Codes 00000 and 10100-11111 are no-ops: no register change, no ld_err.
- Reset (async, rst_n=0): all registers, mem_wr_addr and mem_wr_data cleared to 0; mem_wr_req=0, busy=0, ld_err=0; FSM goes to IDLE.
  - Reset during MEM_WAIT drops the request immediately; the write is abandoned.
- Register load: ld=1 with a register code updates that register on the same rising edge (one-cycle latency, visible next cycle). Loads of registers are accepted regardless of busy.
- Increment: inc=1 with inc_sel in {AR, RP, C1, C2, C3, AC} adds 1 modulo 2^WIDTH (FF wraps to 00). Other inc_sel codes are no-ops.
- Same-cycle ld and inc:
  - Same target: the load wins and the increment is dropped.
  - Different targets: both take effect.
- FSM states IDLE and MEM_WAIT.
  - IDLE, ld=1, dest_sel=MEM: latch mem_wr_data=bus_in and mem_wr_addr=ar (pre-edge value). Next cycle mem_wr_req=1, busy=1, state MEM_WAIT.
  - MEM_WAIT: hold req, addr and data stable until mem_wr_ack is sampled 1. On that edge req=0, busy=0, state IDLE. Minimum request length is 1 cycle.
  - MEM_WAIT, ld=1, dest_sel=MEM: rejected, ld_err=1 for one cycle, latched address and data unchanged.
  - The ack sampled and a new MEM load in the same cycle are also rejected: no back-to-back acceptance, one idle cycle between writes.
  - mem_wr_ack while IDLE is ignored.
- An AR load or increment during MEM_WAIT does not alter mem_wr_addr.
- ld_err is otherwise 0.

Decomposition:
- Shared package bus_codes_pkg: 5-bit code constants (SEL_AC ... SEL_RL2, SEL_MEM) and WIDTH default, also used by the bus source mux, so the two ends never disagree.
- Sub-module bus_mem_wr_fsm holds the IDLE/MEM_WAIT FSM with the addr/data latches, busy and ld_err.
- The register bank and increment logic stay in the top level.

Test Plan:
- Reset, then ld with dest_sel=01101, bus_in=8'hA5 -> dr=A5 the next cycle; all other registers remain 00.
- ar=8'h10, ld with MEM, bus_in=8'h3C -> next cycle mem_wr_req=1, addr=10, data=3C, busy=1. Hold ack low 3 cycles: outputs stable. Ack=1 -> req=0, busy=0 the following cycle.
- During MEM_WAIT, second ld with MEM -> ld_err pulses once, addr/data unchanged; simultaneous inc of AR -> ar=11, mem_wr_addr stays 10.
- c1=8'hFF, inc with inc_sel=00100 -> c1=00, cnt_zero[0]=1. Same cycle: ld C1=07 and inc C1 -> c1=07.
- ld with dest_sel=11111 and with 00000 -> no register change, ld_err=0. Stray mem_wr_ack in IDLE -> no effect.
- Assert rst_n=0 asynchronously mid-MEM_WAIT -> mem_wr_req, busy and all registers go to 0 without a clock edge.
